// File: rtl/postadder_sched.sv
// postadder_sched: command scheduler in front of the postadder.
// Accepts accumulate commands over valid/ready, issues mode1..3/addr2/addr3,
// tracks the op count of each of the nine accumulator slots and forces a
// drain before a slot's L3 carry field can overflow.
// Optional build macro POSTADDER_SCHED_PERF_EN adds the stall_cnt/drain_cnt
// performance counter ports.
module postadder_sched #(
  parameter int ACC_LIMIT = 128,
  parameter int PA_LAT    = 1,
  parameter int CNT_W     = 8
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_acc,
  input  logic [2:0] cmd_mode,
  input  logic [1:0] cmd_addr,
  input  logic       cmd_drain,
  output logic [2:0] mode1,
  output logic [2:0] mode2,
  output logic [2:0] mode3,
  output logic [1:0] addr2,
  output logic [1:0] addr3,
  output logic [1:0] outsel,
  output logic       drain_valid,
  input  logic       drain_ready,
  output logic [3:0] drain_slot,
  output logic       busy
`ifdef POSTADDER_SCHED_PERF_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [15:0] drain_cnt
`endif
);

  localparam int                WAIT_W    = (PA_LAT > 1) ? $clog2(PA_LAT) : 1;
  localparam logic [CNT_W-1:0]  LIMIT     = CNT_W'(ACC_LIMIT);
  localparam logic [CNT_W-1:0]  LIMIT_M1  = CNT_W'(ACC_LIMIT - 1);
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(PA_LAT - 1);

  typedef enum logic [1:0] {S_RUN, S_WAIT, S_DRAIN, S_CLEAR} state_e;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [3:0]        dslot_q, dslot_d;
  logic [2:0]        mode1_q, mode1_d, mode2_q, mode2_d, mode3_q, mode3_d;
  logic [1:0]        addr2_q, addr2_d, addr3_q, addr3_d;
  logic [CNT_W-1:0]  cnt_q [9];
  logic [CNT_W-1:0]  cnt_d [9];

  logic       accept, legal, is_inc, ovf, drain_req, any_sat;
  logic [3:0] cmd_idx, dslot_idx;

  // Slot numbering: acc1 -> 0, acc2[a] -> 1+a, acc3[a] -> 5+a.
  function automatic logic [3:0] slot_idx(input logic [1:0] acc, input logic [1:0] addr);
    case (acc)
      2'd2:    slot_idx = 4'd1 + {2'b00, addr};
      2'd3:    slot_idx = 4'd5 + {2'b00, addr};
      default: slot_idx = 4'd0;
    endcase
  endfunction

  // Increment that sticks at ACC_LIMIT instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    sat_inc = (c >= LIMIT) ? LIMIT : c + CNT_W'(1);
  endfunction

  assign cmd_idx   = slot_idx(cmd_acc, cmd_addr);
  assign dslot_idx = slot_idx(dslot_q[3:2], dslot_q[1:0]);
  assign cmd_ready = rstn && (state_q == S_RUN);
  assign accept    = cmd_valid && cmd_ready;
  assign legal     = (cmd_mode <= 3'b101);
  assign is_inc    = legal && (cmd_mode >= 3'b010);
  assign ovf       = is_inc && (cnt_q[cmd_idx] == LIMIT_M1);
  assign drain_req = accept && (cmd_acc != 2'd0) && (cmd_drain || ovf);

  // Next-state logic: command issue, slot counting and the drain sequence.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    dslot_d = dslot_q;
    mode1_d = 3'b000;
    mode2_d = 3'b000;
    mode3_d = 3'b000;
    addr2_d = addr2_q;
    addr3_d = addr3_q;
    for (int i = 0; i < 9; i++) cnt_d[i] = cnt_q[i];
    case (state_q)
      S_RUN: begin
        if (accept) begin
          if (cmd_acc == 2'd2) addr2_d = cmd_addr;
          if (cmd_acc == 2'd3) addr3_d = cmd_addr;
          if (legal && (cmd_acc != 2'd0)) begin
            case (cmd_acc)
              2'd1:    mode1_d = cmd_mode;
              2'd2:    mode2_d = cmd_mode;
              default: mode3_d = cmd_mode;
            endcase
            if (cmd_mode == 3'b001) cnt_d[cmd_idx] = CNT_W'(1);
            else if (is_inc)        cnt_d[cmd_idx] = sat_inc(cnt_q[cmd_idx]);
          end
          if (drain_req) begin
            state_d = S_WAIT;
            wait_d  = WAIT_INIT;
            dslot_d = {cmd_acc, (cmd_acc == 2'd1) ? 2'b00 : cmd_addr};
          end
        end
      end
      S_WAIT: begin
        if (wait_q == '0) state_d = S_DRAIN;
        else              wait_d  = wait_q - WAIT_W'(1);
      end
      S_DRAIN: begin
        // On acknowledge, the following cycle issues the slot clear (mode 001,
        // datapath supplies zero) and the internal count restarts from zero.
        if (drain_ready) begin
          state_d          = S_CLEAR;
          cnt_d[dslot_idx] = '0;
          case (dslot_q[3:2])
            2'd1:    mode1_d = 3'b001;
            2'd2:    mode2_d = 3'b001;
            default: mode3_d = 3'b001;
          endcase
        end
      end
      S_CLEAR: state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  // State and issue registers; reset abandons any drain in progress.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_RUN;
      wait_q  <= '0;
      dslot_q <= '0;
      mode1_q <= 3'b000;
      mode2_q <= 3'b000;
      mode3_q <= 3'b000;
      addr2_q <= 2'b00;
      addr3_q <= 2'b00;
      for (int i = 0; i < 9; i++) cnt_q[i] <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      dslot_q <= dslot_d;
      mode1_q <= mode1_d;
      mode2_q <= mode2_d;
      mode3_q <= mode3_d;
      addr2_q <= addr2_d;
      addr3_q <= addr3_d;
      for (int i = 0; i < 9; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign mode1       = mode1_q;
  assign mode2       = mode2_q;
  assign mode3       = mode3_q;
  assign addr2       = addr2_q;
  assign addr3       = addr3_q;
  assign drain_valid = (state_q == S_DRAIN);
  assign outsel      = drain_valid ? dslot_q[3:2] : 2'b00;
  assign drain_slot  = drain_valid ? dslot_q : 4'b0000;
  assign busy        = (state_q != S_RUN) || (|{mode1_q, mode2_q, mode3_q});

  // Flags any slot sitting at the saturation value.
  always_comb begin
    any_sat = 1'b0;
    for (int i = 0; i < 9; i++) if (cnt_q[i] == LIMIT) any_sat = 1'b1;
  end

  // A saturated slot must always be on its way to a drain.
  assert property (@(posedge clk) disable iff (!rstn) (state_q == S_RUN) |-> !any_sat);

`ifdef POSTADDER_SCHED_PERF_EN
  logic [31:0] stall_q;
  logic [15:0] dcnt_q;

  // Saturating counts of stalled command cycles and completed drains.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      stall_q <= '0;
      dcnt_q  <= '0;
    end else begin
      if (cmd_valid && !cmd_ready && (stall_q != '1)) stall_q <= stall_q + 32'd1;
      if (drain_valid && drain_ready && (dcnt_q != '1)) dcnt_q <= dcnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
  assign drain_cnt = dcnt_q;
`endif

endmodule
